// File: rtl/playfield_renderer_if.sv
// playfield_renderer_if: frame request handshake, bitmap read port and pixel stream.
interface playfield_renderer_if #(
    parameter int ADDR_W = 14,
    parameter int COL_W  = 3
);
    logic              start;
    logic              sprite_en;
    logic [7:0]        sprite_x;
    logic [7:0]        sprite_y;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rdata;
    logic              busy;
    logic              done;
    logic [7:0]        x;
    logic [7:0]        y;
    logic [COL_W-1:0]  colour;
    logic              plot;
    modport master (
        output start, sprite_x, sprite_y, sprite_en, mem_rdata,
        input  mem_addr, busy, done, x, y, colour, plot
    );
    modport slave (
        input  start, sprite_x, sprite_y, sprite_en, mem_rdata,
        output mem_addr, busy, done, x, y, colour, plot
    );
endinterface

// File: rtl/playfield_renderer.sv
// playfield_renderer: scans a column-major playfield bitmap, then overlays a clipped sprite.
module playfield_renderer #(
    parameter int               FIELD_W     = 120,
    parameter int               FIELD_H     = 100,
    parameter int               X_OFF       = 20,
    parameter int               Y_OFF       = 10,
    parameter int               SPR_W       = 4,
    parameter int               SPR_H       = 6,
    parameter int               COL_W       = 3,
    parameter logic [COL_W-1:0] WALL_COLOUR = 3'b111,
    parameter logic [COL_W-1:0] BG_COLOUR   = 3'b000,
    parameter logic [COL_W-1:0] SPR_COLOUR  = 3'b100,
    parameter int               ADDR_W      = 14
) (
    input logic                 clk,
    input logic                 reset,
    playfield_renderer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, WALL, DRAIN, SPRITE, DONE} state_t;
    localparam logic [7:0] LAST_COL = 8'(FIELD_W - 1);
    localparam logic [7:0] LAST_ROW = 8'(FIELD_H - 1);
    localparam logic [7:0] SW       = 8'(SPR_W);
    localparam logic [7:0] LAST_DY  = 8'(SPR_H - 1);
    localparam logic [7:0] XO       = 8'(X_OFF);
    localparam logic [7:0] YO       = 8'(Y_OFF);
    localparam logic [8:0] FW9      = 9'(FIELD_W);
    localparam logic [8:0] FH9      = 9'(FIELD_H);

    state_t            st, nx;
    logic [7:0]        col, row, dx, dy, spr_x, spr_y, x_q, y_q, x_d, y_d;
    logic              spr_en, wall_px, wall_d, plot_q, plot_d, busy_q, done_q, last_px, spr_on;
    logic [ADDR_W-1:0] addr;
    logic [COL_W-1:0]  colour_q, colour_d;
    logic [8:0]        sx, sy;

    assign last_px = col == LAST_COL && row == LAST_ROW;
    assign spr_on  = (st == DRAIN || st == SPRITE) && dx != SW;
    assign sx      = {1'b0, spr_x} + {1'b0, dx};
    assign sy      = {1'b0, spr_y} + {1'b0, dy};

    always_ff @(posedge clk or posedge reset)
        if (reset) st <= IDLE;
        else st <= nx;

    always_comb begin
        nx = st;
        case (st)
            IDLE:    nx = bus.start ? WALL : IDLE;
            WALL:    nx = last_px ? DRAIN : WALL;
            DRAIN:   nx = spr_en ? SPRITE : DONE;
            SPRITE:  nx = dx == SW ? DONE : SPRITE;
            DONE:    nx = IDLE;
            default: nx = IDLE;
        endcase
    end

    always_comb begin
        wall_d   = st == WALL;
        plot_d   = wall_d || (spr_on && spr_en && sx < FW9 && sy < FH9);
        x_d      = wall_d ? col + XO : sx[7:0] + XO;
        y_d      = wall_d ? row + YO : sy[7:0] + YO;
        colour_d = spr_on ? SPR_COLOUR : BG_COLOUR;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            {col, row, dx, dy, spr_x, spr_y} <= '0;
            spr_en <= 1'b0;
            addr   <= '0;
        end else begin
            if (st == IDLE && bus.start) begin
                spr_x  <= bus.sprite_x;
                spr_y  <= bus.sprite_y;
                spr_en <= bus.sprite_en;
                {col, row, dx, dy} <= '0;
                addr   <= '0;
            end
            if (st == WALL && !last_px) begin
                row  <= row == LAST_ROW ? 8'd0 : row + 8'd1;
                col  <= row == LAST_ROW ? col + 8'd1 : col;
                addr <= addr + ADDR_W'(1);
            end
            if (spr_on) begin
                dy <= dy == LAST_DY ? 8'd0 : dy + 8'd1;
                dx <= dy == LAST_DY ? dx + 8'd1 : dx;
            end
        end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            {x_q, y_q} <= '0;
            colour_q   <= '0;
            {plot_q, busy_q, done_q, wall_px} <= '0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            wall_px  <= wall_d;
            busy_q   <= nx != IDLE;
            done_q   <= nx == DONE;
        end

    // mem_rdata already comes out of the memory's read register, so wall colour selects it directly
    assign bus.colour   = wall_px ? (bus.mem_rdata ? WALL_COLOUR : BG_COLOUR) : colour_q;
    assign bus.mem_addr = addr;
    assign bus.x        = x_q;
    assign bus.y        = y_q;
    assign bus.plot     = plot_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule
